// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: stall/redirect control in, imem address/data, F/D register
// and performance counters out. master = fetch stage, slave = surrounding core.
interface fetch_stage_if #(
  parameter int IMEM_ADDR_W = 12,
  parameter int CNT_W       = 16
);
  logic                   stall;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [31:0]            imem_q;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            pc;
  logic [31:0]            fd_instruction;
  logic [31:0]            fd_pcplus1;
  logic                   fd_valid;
  logic                   flush;
  logic [CNT_W-1:0]       stall_cycles;
  logic [CNT_W-1:0]       flush_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_q,
    output imem_addr, pc, fd_instruction, fd_pcplus1, fd_valid, flush,
           stall_cycles, flush_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_q,
    input  imem_addr, pc, fd_instruction, fd_pcplus1, fd_valid, flush,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register plus F/D pipeline register; 1-cycle fetch-to-decode, 2-bubble redirect.
// Backpressure: stall freezes PC and F/D; redirect overrides stall and squashes F/D.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          IMEM_ADDR_W = 12,
  parameter int          CNT_W       = 16
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);
  logic [31:0]      pc_r;
  logic [31:0]      fd_instruction_r;
  logic [31:0]      fd_pcplus1_r;
  logic             fd_valid_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_count_r;
  logic [31:0]      pc_next_seq;

  assign pc_next_seq = pc_r + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r             <= RESET_PC;
      fd_instruction_r <= 32'd0;
      fd_pcplus1_r     <= 32'd0;
      fd_valid_r       <= 1'b0;
      stall_cycles_r   <= '0;
      flush_count_r    <= '0;
    end else if (bus.redirect) begin
      // The stalled instruction is wrong-path, so it is not charged as a stall.
      pc_r             <= bus.redirect_pc;
      fd_instruction_r <= 32'd0;
      fd_pcplus1_r     <= 32'd0;
      fd_valid_r       <= 1'b0;
      if (flush_count_r != '1) flush_count_r <= flush_count_r + CNT_W'(1);
    end else if (bus.stall) begin
      if (stall_cycles_r != '1) stall_cycles_r <= stall_cycles_r + CNT_W'(1);
    end else begin
      pc_r             <= pc_next_seq;
      fd_instruction_r <= bus.imem_q;
      fd_pcplus1_r     <= pc_next_seq;
      fd_valid_r       <= 1'b1;
    end
  end

  // imem_addr comes straight from the PC register so it only moves at edges.
  assign bus.imem_addr      = pc_r[IMEM_ADDR_W-1:0];
  assign bus.pc             = pc_r;
  assign bus.fd_instruction = fd_instruction_r;
  assign bus.fd_pcplus1     = fd_pcplus1_r;
  assign bus.fd_valid       = fd_valid_r;
  assign bus.flush          = bus.redirect & ~reset;
  assign bus.stall_cycles   = stall_cycles_r;
  assign bus.flush_count    = flush_count_r;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a behavioural model.
module tb_fetch_stage;
  localparam int AW   = 12;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_stage_if #(.IMEM_ADDR_W(AW), .CNT_W(CW)) bus ();

  fetch_stage #(.RESET_PC(32'd0), .IMEM_ADDR_W(AW), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.imem_q = 32'h1000_0000 + 32'(bus.imem_addr);

  // Reference state
  logic [31:0] m_pc, m_fdi, m_fdp;
  logic        m_fdv;
  int          m_stall_cnt, m_flush_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a % (1 << AW));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs (called at negedge), check comb outputs, step
  // model at the edge, then check registered state at the following negedge.
  task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    reset = r; bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    #1;
    check("flush", 32'(bus.flush), 32'(rd & ~r));
    check("imem_addr", 32'(bus.imem_addr), m_pc % (1 << AW));
    @(posedge clock);
    if (r) begin
      m_pc = 0; m_fdi = 0; m_fdp = 0; m_fdv = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else if (rd) begin
      m_pc = rpc; m_fdi = 0; m_fdp = 0; m_fdv = 0;
      m_flush_cnt = (m_flush_cnt < CMAX) ? m_flush_cnt + 1 : CMAX;
    end else if (st) begin
      m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : CMAX;
    end else begin
      m_fdi = mem_word(m_pc);
      m_pc  = m_pc + 32'd1;
      m_fdp = m_pc;
      m_fdv = 1'b1;
    end
    @(negedge clock);
    check("pc", bus.pc, m_pc);
    check("fd_instruction", bus.fd_instruction, m_fdi);
    check("fd_pcplus1", bus.fd_pcplus1, m_fdp);
    check("fd_valid", 32'(bus.fd_valid), 32'(m_fdv));
    check("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall_cnt));
    check("flush_count", 32'(bus.flush_count), 32'(m_flush_cnt));
  endtask

  initial begin
    m_pc = 0; m_fdi = 0; m_fdp = 0; m_fdv = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
    @(negedge clock);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h55);
    check("reset_pc", bus.pc, 32'd0);
    check("reset_valid", 32'(bus.fd_valid), 32'd0);

    // Free run from reset
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      check("run_instr", bus.fd_instruction, 32'h1000_0000 + 32'(i));
      check("run_pcplus1", bus.fd_pcplus1, 32'(i + 1));
      check("run_valid", 32'(bus.fd_valid), 32'd1);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("pc_at_5", bus.pc, 32'd5);

    // Three-cycle stall at pc=5
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      check("stall_pc", bus.pc, 32'd5);
      check("stall_fd", bus.fd_instruction, 32'h1000_0004);
    end
    check("stall_cnt3", 32'(bus.stall_cycles), 32'd3);
    cycle(0, 0, 0, 0);
    check("resume_pc", bus.pc, 32'd6);

    // Redirect to 0x40 at pc=9
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("pc_at_9", bus.pc, 32'd9);
    cycle(0, 0, 1, 32'h40);
    check("redir_pc", bus.pc, 32'h40);
    check("redir_squash", bus.fd_instruction, 32'd0);
    check("redir_valid", 32'(bus.fd_valid), 32'd0);
    cycle(0, 0, 0, 0);
    check("target_instr", bus.fd_instruction, 32'h1000_0040);
    check("target_pcplus1", bus.fd_pcplus1, 32'h41);
    check("flush_cnt1", 32'(bus.flush_count), 32'd1);

    // Redirect together with stall
    cycle(0, 1, 1, 32'h80);
    check("rs_pc", bus.pc, 32'h80);
    check("rs_stall_cnt", 32'(bus.stall_cycles), 32'd3);

    // PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFF);
    cycle(0, 0, 0, 0);
    check("wrap_pc", bus.pc, 32'd0);
    check("wrap_pcplus1", bus.fd_pcplus1, 32'd0);
    check("wrap_addr", 32'(bus.imem_addr), 32'd0);

    // Counter saturation, then reset during stall
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
    check("stall_sat", 32'(bus.stall_cycles), 32'd15);
    cycle(1, 1, 1, 32'h123);
    check("rst_stall_cnt", 32'(bus.stall_cycles), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_count), 32'd0);
    check("rst_pc", bus.pc, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic r, st, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(63) == 0);
      st  = ($urandom_range(3) == 0);
      rd  = ($urandom_range(7) == 0);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(2)) : $urandom;
      cycle(r, st, rd, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
